// File: rtl/tree_deserializer.sv
// Serial-to-parallel receiver: hunts for a training word to find the word
// boundary, then emits N-bit words with the serializer's slot ordering undone.
module tree_deserializer #(
    parameter int                    INPUTS_NUM    = 8,
    parameter int                    STAGES_NUM    = $clog2(INPUTS_NUM),
    parameter bit                    BIT_REVERSE   = 1'b1,
    parameter logic [INPUTS_NUM-1:0] TRAIN_PATTERN = INPUTS_NUM'('h17)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  SERIAL_IN,
    input  logic                  RELOCK,
    input  logic                  BITSLIP,
    output logic [INPUTS_NUM-1:0] PAR_OUT,
    output logic                  PAR_VALID,
    output logic                  LOCKED
);

    localparam int                    N    = INPUTS_NUM;
    localparam logic [STAGES_NUM-1:0] LAST = STAGES_NUM'(N - 1);

    typedef enum logic {
        S_HUNT   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t                state, state_next;
    logic [N-1:0]          sr, nxt, mapped;
    logic [STAGES_NUM-1:0] fill, fill_next;
    logic [STAGES_NUM-1:0] cnt, cnt_next;
    logic                  match, emit;

    // Slot k of the received window lands on output bit bitrev(k) (or k).
    function automatic logic [N-1:0] map_word(input logic [N-1:0] x);
        logic [N-1:0]          y;
        logic [STAGES_NUM-1:0] k_idx, r_idx;
        y     = '0;
        r_idx = '0;
        for (int k = 0; k < N; k++) begin
            k_idx = STAGES_NUM'(k);
            for (int b = 0; b < STAGES_NUM; b++) begin
                r_idx[b] = k_idx[STAGES_NUM-1-b];
            end
            if (BIT_REVERSE) y[r_idx] = x[k];
            else             y[k_idx] = x[k];
        end
        return y;
    endfunction

    assign nxt    = {SERIAL_IN, sr[N-1:1]};
    assign mapped = map_word(nxt);
    // Only a full window of post-hunt bits may lock, never reset zeros.
    assign match  = (fill == LAST) && (mapped == TRAIN_PATTERN);
    assign LOCKED = (state == S_LOCKED);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= S_HUNT;
        else        state <= state_next;
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave it unassigned and infer a latch.
        state_next = state;
        if (RELOCK) begin
            state_next = S_HUNT;
        end else if (state == S_HUNT && match) begin
            state_next = S_LOCKED;
        end
    end

    always_comb begin
        emit      = 1'b0;
        fill_next = fill;
        cnt_next  = cnt;
        if (RELOCK) begin
            fill_next = '0;
            cnt_next  = '0;
        end else begin
            case (state)
                S_HUNT: begin
                    if (match) begin
                        emit     = 1'b1;
                        cnt_next = '0;
                    end else if (fill != LAST) begin
                        fill_next = fill + 1'b1;
                    end
                end
                S_LOCKED: begin
                    // A slip freezes the counter for one bit, pushing every later boundary back.
                    if (BITSLIP) begin
                        cnt_next = cnt;
                    end else if (cnt == LAST) begin
                        emit     = 1'b1;
                        cnt_next = '0;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    cnt_next = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sr        <= '0;
            fill      <= '0;
            cnt       <= '0;
            PAR_OUT   <= '0;
            PAR_VALID <= 1'b0;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
            sr        <= nxt;
            fill      <= fill_next;
            cnt       <= cnt_next;
            PAR_VALID <= emit;
            if (emit) PAR_OUT <= mapped;
        end
    end

endmodule

// File: tb/tb_tree_deserializer.sv
// Randomized bench for tree_deserializer: an N=8 bit-reversed instance and an
// N=4 identity-mapped instance share stimulus and are checked against a bit-history model.
module tb_tree_deserializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       serial = 1'b0;
    logic       relock = 1'b0;
    logic       bitslip = 1'b0;
    logic [7:0] po8;
    logic       pv8, lk8;
    logic [3:0] po4;
    logic       pv4, lk4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tree_deserializer #(.INPUTS_NUM(8)) u_dut8 (
        .CLK(clk), .RESET(rst_n), .SERIAL_IN(serial), .RELOCK(relock),
        .BITSLIP(bitslip), .PAR_OUT(po8), .PAR_VALID(pv8), .LOCKED(lk8)
    );

    tree_deserializer #(
        .INPUTS_NUM(4), .BIT_REVERSE(1'b0), .TRAIN_PATTERN(4'h1)
    ) u_dut4 (
        .CLK(clk), .RESET(rst_n), .SERIAL_IN(serial), .RELOCK(relock),
        .BITSLIP(bitslip), .PAR_OUT(po4), .PAR_VALID(pv4), .LOCKED(lk4)
    );

    // Reference model: the last N received bits, bits seen since the hunt
    // began, and bits gathered into the current word once locked.
    bit          sel = 1'b0;
    int          m_n = 8;
    bit          m_br = 1'b1;
    logic [31:0] m_pat = 32'h17;
    bit          win[$];
    bit          m_hunting;
    int          m_since, m_nbits;
    logic [31:0] m_out;
    bit          m_valid;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rev_idx(input int k);
        int r = 0;
        int t = k;
        for (int b = 0; b < $clog2(m_n); b++) begin
            r = r * 2 + t % 2;
            t = t / 2;
        end
        return r;
    endfunction

    function automatic int slot_pos(input int k);
        return m_br ? rev_idx(k) : k;
    endfunction

    function automatic logic [31:0] window_word();
        logic [31:0] w = '0;
        for (int k = 0; k < m_n; k++) w[slot_pos(k)] = win[k];
        return w;
    endfunction

    task automatic model_reset();
        win.delete();
        for (int k = 0; k < m_n; k++) win.push_back(1'b0);
        m_hunting = 1'b1;
        m_since   = 0;
        m_nbits   = 0;
        m_out     = '0;
        m_valid   = 1'b0;
    endtask

    task automatic model_edge(input bit ser, input bit rl, input bit bs);
        win.push_back(ser);
        void'(win.pop_front());
        m_valid = 1'b0;
        if (rl) begin
            m_hunting = 1'b1;
            m_since   = 0;
        end else if (m_hunting) begin
            m_since++;
            if (m_since >= m_n && window_word() == m_pat) begin
                m_hunting = 1'b0;
                m_nbits   = 0;
                m_out     = window_word();
                m_valid   = 1'b1;
            end
        end else if (!bs) begin
            m_nbits++;
            if (m_nbits == m_n) begin
                m_out   = window_word();
                m_valid = 1'b1;
                m_nbits = 0;
            end
        end
    endtask

    task automatic compare_all();
        if (sel) begin
            check("par_out", 32'(po4), m_out);
            check("par_valid", 32'(pv4), 32'(m_valid));
            check("locked", 32'(lk4), 32'(!m_hunting));
        end else begin
            check("par_out", 32'(po8), m_out);
            check("par_valid", 32'(pv8), 32'(m_valid));
            check("locked", 32'(lk8), 32'(!m_hunting));
        end
    endtask

    task automatic step(input bit ser, input bit rl, input bit bs);
        serial  = ser;
        relock  = rl;
        bitslip = bs;
        @(posedge clk);
        model_edge(ser, rl, bs);
        #1;
        compare_all();
        relock  = 1'b0;
        bitslip = 1'b0;
    endtask

    task automatic send_slots(input logic [31:0] slots, input int n);
        for (int k = 0; k < n; k++) step(slots[k], 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input bit slip_last);
        for (int k = 0; k < m_n; k++) step(w[slot_pos(k)], 1'b0, slip_last && (k == m_n - 1));
    endtask

    task automatic hold_reset();
        for (int i = 0; i < 3; i++) begin
            serial = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            compare_all();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        hold_reset();
    endtask

    task automatic sync_boundary();
        for (int i = 0; i < 2 * m_n && !m_valid; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("boundary_found", 32'(sel ? pv4 : pv8), 32'd1);
    endtask

    task automatic rand_traffic(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            if (m_hunting && m_since >= m_n && $urandom_range(0, 3) == 0)
                send_word(m_pat, 1'b0);
            else
                step(1'($urandom_range(0, 1)), $urandom_range(0, 79) == 0,
                     $urandom_range(0, 15) == 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [7:0] lock_slots;
        lock_slots = 8'b0001_0111;
        model_reset();
        #2;
        compare_all();
        do_reset();

        // Lock after a random prefix, then decode a single set slot.
        repeat (3) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        send_slots(32'(lock_slots), 8);
        check("lock_word", 32'(po8), 32'h17);
        check("lock_valid", 32'(pv8), 32'd1);
        check("lock_up", 32'(lk8), 32'd1);
        send_slots(32'h10, 8);
        check("decode_h02", 32'(po8), 32'h02);
        repeat (5) send_word(32'($urandom_range(0, 255)), 1'b0);

        // Bit slip on the last bit of a word delays the strobe by one bit.
        send_word(32'h01, 1'b1);
        check("slip_no_strobe", 32'(pv8), 32'd0);
        step(1'b0, 1'b0, 1'b0);
        check("slip_word", 32'(po8), 32'h00);
        check("slip_strobe", 32'(pv8), 32'd1);
        repeat (7) step(1'b0, 1'b0, 1'b0);
        repeat (4) send_word(32'($urandom_range(0, 255)), 1'b0);

        // Relock mid-word, then re-acquire.
        sync_boundary();
        repeat (3) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
        check("relock_drop", 32'(lk8), 32'd0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        send_word(m_pat, 1'b0);
        check("relock_reacquire", 32'(lk8), 32'd1);

        // Pattern completing only 5 bits after a relock must be ignored.
        for (int k = 0; k < 8; k++) step(lock_slots[k], k == 2, 1'b0);
        check("early_guard", 32'(lk8), 32'd0);
        send_slots(32'(lock_slots), 8);
        check("early_then_lock", 32'(lk8), 32'd1);

        // Relock on the very edge that completes a match wins.
        step(1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) step(lock_slots[k], k == 7, 1'b0);
        check("relock_beats_match", 32'(lk8), 32'd0);
        send_slots(32'(lock_slots), 8);
        check("lock_after_restart", 32'(lk8), 32'd1);

        // Asynchronous reset mid-word clears outputs without a clock edge.
        sync_boundary();
        repeat (5) step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_par_out", 32'(po8), 32'h0);
        check("async_valid", 32'(pv8), 32'd0);
        check("async_locked", 32'(lk8), 32'd0);
        hold_reset();

        rand_traffic(400);

        // Identity mapping, N=4, training word 'h1.
        sel   = 1'b1;
        m_n   = 4;
        m_br  = 1'b0;
        m_pat = 32'h1;
        do_reset();
        send_slots(32'b0001, 4);
        check("n4_lock", 32'(lk4), 32'd1);
        check("n4_lock_word", 32'(po4), 32'h1);
        send_slots(32'b0110, 4);
        check("n4_decode_h6", 32'(po4), 32'h6);
        rand_traffic(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
